intr_ctrl_8: RTL
================

// Module: intr_ctrl_8
// PURPOSE
//  8-source vectored interrupt controller built around the 8:3 priority encoder.
//  Captures request edges into a pending register and applies a mask.
//  Presents the highest-priority unmasked source as irq/irq_id, then sequences ack -> service -> eoi.
//  Sits between peripheral request lines and the CPU/sequencer that services them.
// PARAMETERS
//  N_SRC   8  number of request sources (fixed; encoder is 8:3)
//  ID_W    3  width of irq_id
//  EDGE    1  1 = rising-edge capture into pending; 0 = level (pending follows req_in high)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req_in     in   8      raw request lines (synchronous to clk); bit 7 = highest priority
//  mask_wr    in   1      write strobe for mask register
//  mask_din   in   8      mask value (1 = source masked)
//  mask_q     out  8      current mask register
//  pending_q  out  8      current pending register
//  irq        out  1      interrupt to host, registered
//  irq_id     out  3      vector of presented source, valid while irq=1, registered
//  ack        in   1      host accepts presented interrupt (1-cycle pulse)
//  eoi        in   1      host end-of-interrupt (1-cycle pulse)
//  busy       out  1      1 while a source is in service
// BEHAVIOUR
//  Reset (async, rst_n=0): pending=0, mask=8'hFF, req_d=0, irq=0, irq_id=0, busy=0, state=IDLE.
//  Capture: rise = req_in & ~req_d; req_d <= req_in every cycle.
//   pending <= (pending & ~clr) | set; set = rise (EDGE=1) or req_in (EDGE=0).
//   clr = onehot(irq_id) only on the accepted ack. Set and clear on the same bit -> set wins.
//  eligible = pending & ~mask; encoder: highest set index wins, v = |eligible.
//  Mask: mask_wr loads mask_din at the clock edge; it affects eligible from the next cycle. Writable in any state.
//  FSM, states IDLE / PEND / SERV:
//   IDLE: if v -> PEND; irq<=1, irq_id<=encoder Q (latched).
//   PEND: irq=1, irq_id frozen (no preemption by later higher-priority arrivals).
//     ack=1 -> SERV: irq<=0, busy<=1, clear pending[irq_id].
//     Latched source masked (mask[irq_id]=1) and no ack -> IDLE: irq<=0, pending bit kept.
//     ack and the mask write in the same cycle -> ack wins.
//   SERV: busy=1; new edges keep accumulating in pending.
//     eoi=1 -> IDLE, busy<=0.
//     A pending source is re-presented no earlier than 1 cycle after leaving SERV.
//  Ignored inputs: ack outside PEND; eoi outside SERV; eoi coincident with ack in PEND.
//  Latency: req_in rises before edge k -> pending set at k -> irq=1 after edge k+1 (2 cycles).
//  EDGE=0: a source still high at ack is re-pended next cycle; sources must drop before eoi.
//  Reset mid-operation: all state cleared immediately; an in-flight ack/eoi is lost.
// STRUCTURE
//  Package intr_pkg:
//   N_SRC, ID_W;
//   state localparams ST_IDLE=2'd0, ST_PEND=2'd1, ST_SERV=2'd2.
//  Sub-module: the team's combinational 8:3 priority encoder p_enc_8x3 (D[7:0] -> Q[2:0], v), driven by eligible.
//  Remaining logic (edge detect, pending/mask regs, FSM, output regs) lives in intr_ctrl_8.
// TESTING
//  Reset -> mask_q=FF, pending_q=00, irq=0, busy=0.
//   Then write mask 00; pulse req_in[2] -> irq=1, irq_id=2 exactly 2 cycles later.
//  req_in=8'h81 rising together -> irq_id=7.
//   ack -> pending_q=01, busy=1; eoi -> within 2 cycles irq=1, irq_id=0.
//  In PEND with id=3, raise req_in[6] -> irq_id stays 3 until ack.
//   After eoi -> irq_id=6.
//  In PEND with id=5, write mask 8'h20 -> irq=0 next cycle, pending_q[5]=1.
//   Unmask -> irq_id=5 re-presented.
//  Rising edge of req_in[4] in the same cycle as ack of id=4 -> pending_q[4]=1 after ack (set wins).
//  Assert rst_n=0 in SERV -> busy=0, irq=0, pending_q=0 asynchronously.
//   ack/eoi while IDLE -> no state change.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared sizes and FSM encoding for the 8-source interrupt controller.
package intr_pkg;
  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } state_e;
endpackage

// File: rtl/p_enc_8x3.sv
// Combinational 8:3 priority encoder; the highest set index wins and v flags any set bit.
module p_enc_8x3 (
  input  logic [7:0] d,
  output logic [2:0] q,
  output logic       v
);
  always_comb begin
    q = '0;
    // Ascending scan, so later (higher) indices overwrite lower ones.
    for (int i = 0; i < 8; i++) begin
      if (d[i]) q = 3'(i);
    end
  end

  assign v = |d;
endmodule

// File: rtl/intr_ctrl_8.sv
// Vectored interrupt controller: request capture into pending, masking, and an
// IDLE/PEND/SERV handshake that presents one source at a time to the host.
module intr_ctrl_8
  import intr_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req_in,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_din,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pending_q,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             ack,
  input  logic             eoi,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [N_SRC-1:0] req_d_q, req_d_d;
  logic [N_SRC-1:0] pending_d, mask_d;
  logic             irq_q, irq_d, busy_q, busy_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_SRC-1:0] rise, set, clr, eligible;
  logic [ID_W-1:0]  enc_q;
  logic             enc_v;

  assign eligible = pending_q & ~mask_q;

  p_enc_8x3 u_enc (
    .d (eligible),
    .q (enc_q),
    .v (enc_v)
  );

  always_comb begin
    rise      = req_in & ~req_d_q;
    set       = EDGE ? rise : req_in;
    clr       = '0;
    state_d   = state_q;
    irq_d     = irq_q;
    irq_id_d  = irq_id_q;
    busy_d    = busy_q;
    req_d_d   = req_in;
    mask_d    = mask_wr ? mask_din : mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_v) begin
          state_d  = ST_PEND;
          irq_d    = 1'b1;
          irq_id_d = enc_q;
        end
      end
      ST_PEND: begin
        // Ack takes priority over a mask that just retracted the latched source.
        if (ack) begin
          state_d = ST_SERV;
          irq_d   = 1'b0;
          busy_d  = 1'b1;
          clr     = N_SRC'(1) << irq_id_q;
        end else if (mask_q[irq_id_q]) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_SERV: begin
        if (eoi) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // A new request on the bit being acknowledged survives the clear.
    pending_d = (pending_q & ~clr) | set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_d_q   <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_d_q   <= req_d_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      busy_q    <= busy_d;
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;
  assign busy   = busy_q;
endmodule
